cam_table_arbiter: RTL and testbench
====================================

Name: cam_table_arbiter

Overview:
- Owns the single-port MAC CAM table (TABLE_DEPTH x 48-bit, 1-cycle read latency).
- Shares that table between NUMBER_OF_CLIENTS port orchestrators using round-robin arbitration.
- Serves two request types: learn (write a source MAC at the entry given by the client's port index) and lookup (scan for a destination MAC, report hit/index).
- Keeps per-entry valid bits and 2-bit age counters, so stale entries expire and lookups never match empty or aged-out slots.

Parameters:
- NUMBER_OF_CLIENTS, 2, number of requesting orchestrators.
- TABLE_DEPTH, 16, number of CAM entries (≤16, matches the 4-bit address).
- AGE_PERIOD, 16'hFFFF, cycles between age ticks.

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- client_request  in  [NUMBER_OF_CLIENTS-1:0]  level request; held until the matching done
- client_write  in  [NUMBER_OF_CLIENTS-1:0]  1 = learn, 0 = lookup; stable while request is high
- client_mac  in  [NUMBER_OF_CLIENTS-1:0][47:0]  MAC to learn or look up
- client_port  in  [NUMBER_OF_CLIENTS-1:0][3:0]  entry index for learn
- table_flush  in  1  one-cycle pulse: invalidate all entries
- cam_table_read_data  in  48  entry data, valid 1 cycle after the address
- client_done  out  [NUMBER_OF_CLIENTS-1:0]  one-cycle completion pulse, one-hot
- client_hit  out  1  qualified by any client_done
- client_hit_index  out  4  matching or written entry, qualified by client_hit
- cam_table_read_address  out  4
- cam_table_write_address  out  4
- cam_table_write_data  out  48
- cam_table_write_data_valid  out  1  one-cycle write strobe
- entry_valid  out  [TABLE_DEPTH-1:0]  per-entry valid mask

Behaviour:
- Reset values: all outputs 0; entry_valid 0; ages 0; age timer 0; state S_IDLE; last_grant = NUMBER_OF_CLIENTS-1, so client 0 wins first.
- All outputs are registered. Reset mid-operation aborts any scan with no done pulse.
- Arbitration (S_IDLE only):
  - Eligible = client_request & ~client_done.
  - Search starts at last_grant+1 and wraps modulo NUMBER_OF_CLIENTS. First eligible client is granted; last_grant updates.
  - The granted client's write/mac/port are latched.
- Learn:
  - Decided in S_IDLE at cycle t.
  - At t+1: write_address = port, write_data = mac, write_data_valid = 1, done[c] = 1, hit = 1, hit_index = port. entry_valid[port] = 1 and age[port] = 0.
  - State stays S_IDLE.
  - If port ≥ TABLE_DEPTH: no write, done pulses with hit = 0.
- Lookup:
  - S_IDLE sets read_address = 0, then goes to S_READ_WAIT (1 cycle), then S_COMPARE.
  - S_COMPARE match condition: entry_valid[addr] && read_data == latched mac.
    - Match: done, hit = 1, hit_index = addr; go to S_IDLE.
    - No match at addr == TABLE_DEPTH-1: done with hit = 0; go to S_IDLE.
    - Otherwise: addr + 1, go to S_READ_WAIT.
  - Latency: request sampled at cycle 0; hit at entry k gives done at cycle 2k+3. A miss gives done at cycle 2·TABLE_DEPTH+1 (33 by default).
- Clients must drop (or change) request in the cycle done is seen. The done mask prevents an immediate re-grant of the same transaction.
- Aging:
  - Free-running counter; age_tick pulses when it reaches AGE_PERIOD-1, then the counter wraps to 0.
  - On age_tick, every valid entry with age < 3 increments. A valid entry already at age 3 is invalidated.
  - Entries are refreshed only by a learn.
- Same-cycle priorities, per entry:
  - Learn write beats flush and age_tick (entry ends valid, age 0).
  - Flush beats age_tick.
- Flush or aging during a lookup takes effect immediately. Later compares in the same scan see the new valid bits.
- Only one table operation is in flight at a time. Pending requests wait, with no loss.

Test Plan:
- Reset, client 0 learns MAC 0x001122334455 at port 3 → write strobe with address 3 one cycle later; done[0] = 1, hit = 1, index = 3; entry_valid = 16'h0008.
- Client 1 looks up 0x001122334455 (model returns the table contents) → done[1] at cycle 9 (k = 3), hit = 1, index = 3.
- Lookup of MAC 0 on the empty table → done at cycle 33, hit = 0; read_address sweeps 0..15.
- Both clients request continuously, 4 transactions each → grants alternate 0,1,0,1,…; no starvation; done is always one-hot.
- AGE_PERIOD = 4, one learned entry, no refresh → entry_valid bit clears on the 4th age_tick; a learn in the same cycle as a tick keeps it valid with age 0.
- table_flush asserted mid-scan after a matching entry was written → lookup completes with hit = 0; flush coincident with a learn to port 5 → entry_valid = 16'h0020.

Source files
------------

// File: rtl/cam_table_arbiter.sv
// Round-robin arbiter sharing a single-port MAC CAM table between port
// orchestrators; serves learn (write) and lookup (linear scan) requests and
// maintains per-entry valid bits with 2-bit age counters.
module cam_table_arbiter #(
  parameter int unsigned NUMBER_OF_CLIENTS = 2,
  parameter int unsigned TABLE_DEPTH       = 16,
  parameter logic [15:0] AGE_PERIOD        = 16'hFFFF
) (
  input  logic                                clock,
  input  logic                                reset_n,
  input  logic [NUMBER_OF_CLIENTS-1:0]        client_request,
  input  logic [NUMBER_OF_CLIENTS-1:0]        client_write,
  input  logic [NUMBER_OF_CLIENTS-1:0][47:0]  client_mac,
  input  logic [NUMBER_OF_CLIENTS-1:0][3:0]   client_port,
  input  logic                                table_flush,
  input  logic [47:0]                         cam_table_read_data,
  output logic [NUMBER_OF_CLIENTS-1:0]        client_done,
  output logic                                client_hit,
  output logic [3:0]                          client_hit_index,
  output logic [3:0]                          cam_table_read_address,
  output logic [3:0]                          cam_table_write_address,
  output logic [47:0]                         cam_table_write_data,
  output logic                                cam_table_write_data_valid,
  output logic [TABLE_DEPTH-1:0]              entry_valid
);

  localparam int unsigned MAC_W    = 48;
  localparam int unsigned ADDR_W   = 4;
  localparam int unsigned AGE_W    = 16;
  localparam int unsigned CLIENT_W = (NUMBER_OF_CLIENTS > 1) ? $clog2(NUMBER_OF_CLIENTS) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TABLE_DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ_WAIT,
    S_COMPARE
  } state_t;

  state_t                         state_q;
  logic [CLIENT_W-1:0]            last_grant_q;
  logic [CLIENT_W-1:0]            client_q;
  logic [MAC_W-1:0]               mac_q;
  logic [NUMBER_OF_CLIENTS-1:0]   done_q;
  logic                           hit_q;
  logic [ADDR_W-1:0]              hit_index_q;
  logic [ADDR_W-1:0]              rd_addr_q;
  logic [ADDR_W-1:0]              wr_addr_q;
  logic [MAC_W-1:0]               wr_data_q;
  logic                           wr_valid_q;
  logic [TABLE_DEPTH-1:0]         entry_valid_q;
  logic [1:0]                     age_q [TABLE_DEPTH];
  logic [AGE_W-1:0]               age_cnt_q;

  logic [NUMBER_OF_CLIENTS-1:0]   eligible;
  logic                           grant_found;
  logic [CLIENT_W-1:0]            grant_idx;
  int unsigned                    cand;
  logic                           g_write;
  logic [MAC_W-1:0]               g_mac;
  logic [ADDR_W-1:0]              g_port;
  logic                           port_in_range;
  logic                           learn_fire;
  logic                           age_tick;
  logic [NUMBER_OF_CLIENTS-1:0]   grant_onehot;
  logic [NUMBER_OF_CLIENTS-1:0]   client_onehot;

  // A client whose done is showing is masked so the finished transaction is not re-granted.
  assign eligible = client_request & ~done_q;

  // Round-robin search starting one past the last granted client.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int unsigned off = 1; off <= NUMBER_OF_CLIENTS; off++) begin
      cand = (32'(last_grant_q) + off) % NUMBER_OF_CLIENTS;
      if (!grant_found && eligible[CLIENT_W'(cand)]) begin
        grant_found = 1'b1;
        grant_idx   = CLIENT_W'(cand);
      end
    end
  end

  assign g_write       = client_write[grant_idx];
  assign g_mac         = client_mac[grant_idx];
  assign g_port        = client_port[grant_idx];
  assign port_in_range = ({1'b0, g_port} < 5'(TABLE_DEPTH));
  assign learn_fire    = (state_q == S_IDLE) && grant_found && g_write && port_in_range;
  assign age_tick      = (age_cnt_q == (AGE_PERIOD - 16'd1));
  assign grant_onehot  = NUMBER_OF_CLIENTS'(1) << grant_idx;
  assign client_onehot = NUMBER_OF_CLIENTS'(1) << client_q;

  // Arbitration / scan FSM with registered table and client outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      last_grant_q <= CLIENT_W'(NUMBER_OF_CLIENTS - 1);
      client_q     <= '0;
      mac_q        <= '0;
      done_q       <= '0;
      hit_q        <= 1'b0;
      hit_index_q  <= '0;
      rd_addr_q    <= '0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      wr_valid_q   <= 1'b0;
    end else begin
      done_q      <= '0;
      wr_valid_q  <= 1'b0;
      hit_q       <= 1'b0;
      hit_index_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (grant_found) begin
            last_grant_q <= grant_idx;
            client_q     <= grant_idx;
            mac_q        <= g_mac;
            if (g_write) begin
              done_q <= grant_onehot;
              if (port_in_range) begin
                wr_addr_q   <= g_port;
                wr_data_q   <= g_mac;
                wr_valid_q  <= 1'b1;
                hit_q       <= 1'b1;
                hit_index_q <= g_port;
              end
            end else begin
              rd_addr_q <= '0;
              state_q   <= S_READ_WAIT;
            end
          end
        end
        S_READ_WAIT: begin
          state_q <= S_COMPARE;
        end
        S_COMPARE: begin
          if (entry_valid_q[rd_addr_q] && (cam_table_read_data == mac_q)) begin
            done_q      <= client_onehot;
            hit_q       <= 1'b1;
            hit_index_q <= rd_addr_q;
            state_q     <= S_IDLE;
          end else if (rd_addr_q == LAST_ADDR) begin
            done_q  <= client_onehot;
            state_q <= S_IDLE;
          end else begin
            rd_addr_q <= rd_addr_q + ADDR_W'(1);
            state_q   <= S_READ_WAIT;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Per-entry valid/age: learn beats flush, flush beats age tick.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      entry_valid_q <= '0;
      for (int unsigned i = 0; i < TABLE_DEPTH; i++) begin
        age_q[i] <= 2'd0;
      end
    end else begin
      for (int unsigned i = 0; i < TABLE_DEPTH; i++) begin
        if (learn_fire && (g_port == ADDR_W'(i))) begin
          entry_valid_q[i] <= 1'b1;
          age_q[i]         <= 2'd0;
        end else if (table_flush) begin
          entry_valid_q[i] <= 1'b0;
          age_q[i]         <= 2'd0;
        end else if (age_tick && entry_valid_q[i]) begin
          if (age_q[i] == 2'd3) begin
            entry_valid_q[i] <= 1'b0;
          end else begin
            age_q[i] <= age_q[i] + 2'd1;
          end
        end
      end
    end
  end

  // Free-running age timer, wraps after the tick.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      age_cnt_q <= '0;
    end else if (age_tick) begin
      age_cnt_q <= '0;
    end else begin
      age_cnt_q <= age_cnt_q + AGE_W'(1);
    end
  end

  assign client_done                = done_q;
  assign client_hit                 = hit_q;
  assign client_hit_index           = hit_index_q;
  assign cam_table_read_address     = rd_addr_q;
  assign cam_table_write_address    = wr_addr_q;
  assign cam_table_write_data       = wr_data_q;
  assign cam_table_write_data_valid = wr_valid_q;
  assign entry_valid                = entry_valid_q;

endmodule

// File: tb/tb_cam_table_arbiter.sv
// Directed bench for cam_table_arbiter: learn/lookup timing, round-robin,
// flush interaction, and aging on a short-period second instance.
module tb_cam_table_arbiter;

  localparam int unsigned NC = 2;
  localparam int unsigned TD = 16;
  localparam logic [47:0] MAC_A = 48'h0011_2233_4455;
  localparam logic [47:0] MAC_B = 48'hA0B1_C2D3_E4F5;
  localparam logic [47:0] MAC_C = 48'h0102_0304_0506;
  localparam logic [47:0] MAC_D = 48'hDEAD_BEEF_0001;
  localparam logic [47:0] MAC_E = 48'hCAFE_F00D_0002;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  // main instance
  logic [NC-1:0]        client_request;
  logic [NC-1:0]        client_write;
  logic [NC-1:0][47:0]  client_mac;
  logic [NC-1:0][3:0]   client_port;
  logic                 table_flush;
  logic [47:0]          cam_table_read_data = 48'h0;
  logic [NC-1:0]        client_done;
  logic                 client_hit;
  logic [3:0]           client_hit_index;
  logic [3:0]           cam_table_read_address;
  logic [3:0]           cam_table_write_address;
  logic [47:0]          cam_table_write_data;
  logic                 cam_table_write_data_valid;
  logic [TD-1:0]        entry_valid;

  // short age period instance
  logic [NC-1:0]        a_request;
  logic [NC-1:0]        a_write;
  logic [NC-1:0][47:0]  a_mac;
  logic [NC-1:0][3:0]   a_port;
  logic                 a_flush;
  logic [47:0]          a_read_data = 48'h0;
  logic [NC-1:0]        a_done;
  logic                 a_hit;
  logic [3:0]           a_hit_index;
  logic [3:0]           a_rd_addr;
  logic [3:0]           a_wr_addr;
  logic [47:0]          a_wr_data;
  logic                 a_wr_valid;
  logic [TD-1:0]        a_entry_valid;

  logic [47:0] mem [TD] = '{default: 48'h0};
  logic [3:0]  addr_log [64];
  int          pe_cnt;
  int          vec_cnt = 0;
  int          err_cnt = 0;

  always #5 clock = ~clock;

  cam_table_arbiter u_dut (
    .clock                      (clock),
    .reset_n                    (reset_n),
    .client_request             (client_request),
    .client_write               (client_write),
    .client_mac                 (client_mac),
    .client_port                (client_port),
    .table_flush                (table_flush),
    .cam_table_read_data        (cam_table_read_data),
    .client_done                (client_done),
    .client_hit                 (client_hit),
    .client_hit_index           (client_hit_index),
    .cam_table_read_address     (cam_table_read_address),
    .cam_table_write_address    (cam_table_write_address),
    .cam_table_write_data       (cam_table_write_data),
    .cam_table_write_data_valid (cam_table_write_data_valid),
    .entry_valid                (entry_valid)
  );

  cam_table_arbiter #(.AGE_PERIOD(16'd4)) u_age (
    .clock                      (clock),
    .reset_n                    (reset_n),
    .client_request             (a_request),
    .client_write               (a_write),
    .client_mac                 (a_mac),
    .client_port                (a_port),
    .table_flush                (a_flush),
    .cam_table_read_data        (a_read_data),
    .client_done                (a_done),
    .client_hit                 (a_hit),
    .client_hit_index           (a_hit_index),
    .cam_table_read_address     (a_rd_addr),
    .cam_table_write_address    (a_wr_addr),
    .cam_table_write_data       (a_wr_data),
    .cam_table_write_data_valid (a_wr_valid),
    .entry_valid                (a_entry_valid)
  );

  // single-port table, one-cycle read latency
  always @(posedge clock) begin
    if (cam_table_write_data_valid) mem[cam_table_write_address] <= cam_table_write_data;
    cam_table_read_data <= mem[cam_table_read_address];
  end

  // posedges since reset release; age ticks of u_age land on multiples of 4
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) pe_cnt <= 0;
    else          pe_cnt <= pe_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // one transaction on u_dut; returns cycles until done is seen
  task automatic run_txn(input logic c, input logic wr, input logic [47:0] mac,
                         input logic [3:0] port, input int flush_at,
                         output int cyc, output logic [NC-1:0] dn,
                         output logic ht, output logic [3:0] ix);
    cyc = 0;
    client_write[c]   = wr;
    client_mac[c]     = mac;
    client_port[c]    = port;
    client_request[c] = 1'b1;
    table_flush       = (flush_at == 0);
    while (cyc < 100) begin
      @(negedge clock);
      cyc++;
      if (cyc < 64) addr_log[cyc] = cam_table_read_address;
      table_flush = (cyc == flush_at);
      if (client_done != '0) break;
    end
    client_request[c] = 1'b0;
    table_flush       = 1'b0;
    check("done_seen", 64'(client_done != '0), 64'(1));
    dn = client_done;
    ht = client_hit;
    ix = client_hit_index;
  endtask

  task automatic wait_pe(input int t);
    int g = 0;
    while (pe_cnt < t && g < 10000) begin
      @(negedge clock);
      g++;
    end
  endtask

  // learn on u_age port 7, granted at the posedge that brings pe_cnt to l
  task automatic age_learn(input int l, input logic [47:0] mac, input logic full);
    wait_pe(l - 1);
    a_write[0]   = 1'b1;
    a_mac[0]     = mac;
    a_port[0]    = 4'd7;
    a_request[0] = 1'b1;
    @(negedge clock);
    a_request[0] = 1'b0;
    check("age_learn_done", 64'(a_done), 64'(2'b01));
    check("age_learn_phase", 64'(pe_cnt), 64'(l));
    if (full) begin
      check("age_learn_wstrobe", 64'({a_wr_valid, a_wr_addr, a_hit, a_hit_index}), 64'({1'b1, 4'd7, 1'b1, 4'd7}));
      check("age_learn_wdata", 64'(a_wr_data), 64'(mac));
      check("age_rd_addr", 64'(a_rd_addr), 64'(0));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int              cyc;
    logic [NC-1:0]   dn;
    logic            ht;
    logic [3:0]      ix;
    int              bad;
    int              rem0, rem1, n, guard, bad_onehot;
    logic [7:0]      order;
    logic            last_hit1;
    logic [3:0]      last_idx1;
    int              l1;

    client_request = '0; client_write = '0; client_mac = '0; client_port = '0; table_flush = 1'b0;
    a_request = '0; a_write = '0; a_mac = '0; a_port = '0; a_flush = 1'b0;

    // reset values
    repeat (3) @(negedge clock);
    check("rst_done", 64'({client_done, client_hit, client_hit_index}), 64'(0));
    check("rst_table", 64'({cam_table_read_address, cam_table_write_address, cam_table_write_data_valid}), 64'(0));
    check("rst_wdata", 64'(cam_table_write_data), 64'(0));
    check("rst_valid", 64'({entry_valid, a_entry_valid}), 64'(0));
    reset_n = 1'b1;
    @(negedge clock);

    // client 0 learns MAC_A at port 3
    run_txn(1'b0, 1'b1, MAC_A, 4'd3, -1, cyc, dn, ht, ix);
    check("learn_latency", 64'(cyc), 64'(1));
    check("learn_done", 64'(dn), 64'(2'b01));
    check("learn_hit", 64'({ht, ix}), 64'({1'b1, 4'd3}));
    check("learn_wstrobe", 64'({cam_table_write_data_valid, cam_table_write_address}), 64'({1'b1, 4'd3}));
    check("learn_wdata", 64'(cam_table_write_data), 64'(MAC_A));
    check("learn_valid", 64'(entry_valid), 64'(16'h0008));

    // client 1 finds it at k=3
    run_txn(1'b1, 1'b0, MAC_A, 4'd0, -1, cyc, dn, ht, ix);
    check("lookup_latency", 64'(cyc), 64'(9));
    check("lookup_done", 64'(dn), 64'(2'b10));
    check("lookup_hit", 64'({ht, ix}), 64'({1'b1, 4'd3}));

    // flush, then a full-scan miss
    table_flush = 1'b1;
    @(negedge clock);
    table_flush = 1'b0;
    check("flush_valid", 64'(entry_valid), 64'(0));
    run_txn(1'b0, 1'b0, 48'h0, 4'd0, -1, cyc, dn, ht, ix);
    check("miss_latency", 64'(cyc), 64'(33));
    check("miss_done", 64'(dn), 64'(2'b01));
    check("miss_hit", 64'(ht), 64'(0));
    bad = 0;
    for (int j = 1; j <= 32; j++) begin
      if (addr_log[j] != 4'((j - 1) / 2)) bad++;
    end
    check("miss_sweep_bad", 64'(bad), 64'(0));
    check("miss_sweep_last", 64'(addr_log[32]), 64'(15));

    // both clients busy: client 0 learns port 4, client 1 looks up the same MAC
    @(negedge clock);
    client_write   = 2'b01;
    client_mac[0]  = MAC_B;
    client_mac[1]  = MAC_B;
    client_port[0] = 4'd4;
    client_port[1] = 4'd0;
    client_request = 2'b11;
    rem0 = 4; rem1 = 4; n = 0; guard = 0; bad_onehot = 0; order = '0;
    last_hit1 = 1'b0; last_idx1 = '0;
    while ((rem0 > 0 || rem1 > 0) && guard < 2000) begin
      @(negedge clock);
      guard++;
      if (client_done != '0) begin
        if (!$onehot(client_done)) bad_onehot++;
        if (client_done[0]) begin
          if (n < 8) order[n] = 1'b0;
          rem0--;
        end else begin
          if (n < 8) order[n] = 1'b1;
          last_hit1 = client_hit;
          last_idx1 = client_hit_index;
          rem1--;
        end
        n++;
      end
      client_request[0] = (rem0 > 0) && !client_done[0];
      client_request[1] = (rem1 > 0) && !client_done[1];
    end
    client_request = '0;
    check("rr_bounded", 64'(guard < 2000), 64'(1));
    check("rr_count", 64'(n), 64'(8));
    check("rr_order", 64'(order), 64'(8'h55));
    check("rr_onehot", 64'(bad_onehot), 64'(0));
    check("rr_last_lookup", 64'({last_hit1, last_idx1}), 64'({1'b1, 4'd4}));

    // flush mid-scan kills a hit that would land at k=10
    @(negedge clock);
    run_txn(1'b0, 1'b1, MAC_C, 4'd10, -1, cyc, dn, ht, ix);
    check("pre_flush_valid", 64'(entry_valid), 64'(16'h0410));
    run_txn(1'b1, 1'b0, MAC_C, 4'd0, 4, cyc, dn, ht, ix);
    check("flush_scan_latency", 64'(cyc), 64'(33));
    check("flush_scan_result", 64'({dn, ht}), 64'({2'b10, 1'b0}));
    check("flush_scan_valid", 64'(entry_valid), 64'(0));

    // flush coincident with a learn to port 5
    run_txn(1'b0, 1'b1, MAC_D, 4'd2, -1, cyc, dn, ht, ix);
    check("learn2_valid", 64'(entry_valid), 64'(16'h0004));
    run_txn(1'b1, 1'b1, MAC_E, 4'd5, 0, cyc, dn, ht, ix);
    check("flush_learn_done", 64'({cyc[3:0], dn, ht, ix}), 64'({4'd1, 2'b10, 1'b1, 4'd5}));
    check("flush_learn_valid", 64'(entry_valid), 64'(16'h0020));

    // aging on u_age: ticks at pe_cnt multiples of 4
    l1 = pe_cnt + 2;
    while ((l1 % 4) != 2) l1++;
    age_learn(l1, MAC_A, 1'b1);
    check("age_valid_new", 64'(a_entry_valid), 64'(16'h0080));
    wait_pe(l1 + 13);
    check("age_valid_age3", 64'(a_entry_valid), 64'(16'h0080));
    age_learn(l1 + 14, MAC_B, 1'b0);
    check("age_learn_on_tick", 64'(a_entry_valid), 64'(16'h0080));
    wait_pe(l1 + 29);
    check("age_before_4th", 64'(a_entry_valid), 64'(16'h0080));
    wait_pe(l1 + 30);
    check("age_expired", 64'(a_entry_valid), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
